// File: rtl/raster_scanout.sv
// raster_scanout: reader side of the line-drawing pixel buffer.
//
// On start (sampled in IDLE only) the whole picture is copied into an
// internal snapshot. The snapshot is then streamed out one pixel per
// handshake in raster order: y is the outer loop and x the inner loop.
// Each pixel carries its coordinates and end-of-line/end-of-frame markers.
//
// Ports:
//   clk        system clock, rising edge
//   n_rst      asynchronous active-low reset
//   start      begin a frame; only looked at in IDLE
//   abort      synchronous cancel of the frame in progress (SCAN only)
//   picture    source bitmap, pixel (x,y) = picture[y][x]
//   pix_ready  downstream accepts the current pixel
//   pix_valid  pix_* outputs hold a pixel
//   pix_data   pixel value
//   pix_x      column of the current pixel (zero-extended)
//   pix_y      row of the current pixel (zero-extended)
//   pix_eol    current pixel is the last one in its row
//   pix_eof    current pixel is the last one in the frame
//   busy       high while scanning
//   done       one-cycle pulse after the last pixel transfers
//   set_count  (SCANOUT_PIXCNT_EN only) number of set pixels transferred
//
// Optional feature macro: SCANOUT_PIXCNT_EN adds the set_count output.
//
// Handshake: a pixel transfers on a cycle with pix_valid && pix_ready.
// While pix_valid is high and pix_ready is low every pix_* output holds;
// pix_valid only drops after the last transfer or on abort. abort wins
// over a transfer in the same cycle.

module raster_scanout #(
    parameter int WIDTH      = 64,
    parameter int HEIGHT     = 64,
    parameter int COORD_BITS = 8
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            start,
    input  logic                            abort,
    input  logic [HEIGHT-1:0][WIDTH-1:0]    picture,
    input  logic                            pix_ready,
    output logic                            pix_valid,
    output logic                            pix_data,
    output logic [COORD_BITS-1:0]           pix_x,
    output logic [COORD_BITS-1:0]           pix_y,
    output logic                            pix_eol,
    output logic                            pix_eof,
    output logic                            busy,
    output logic                            done
`ifdef SCANOUT_PIXCNT_EN
    ,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0] set_count
`endif
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                       state;
    state_t                       state_next;
    logic [HEIGHT-1:0][WIDTH-1:0] snap;
    logic [XW-1:0]                x_cnt;
    logic [YW-1:0]                y_cnt;
    logic                         x_last;
    logic                         y_last;
    logic                         frame_start;
    logic                         xfer;

    assign x_last      = (x_cnt == XW'(WIDTH - 1));
    assign y_last      = (y_cnt == YW'(HEIGHT - 1));
    // abort in IDLE suppresses a simultaneous start.
    assign frame_start = (state == S_IDLE) && start && !abort;
    assign xfer        = (state == S_SCAN) && pix_ready && !abort;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (frame_start) state_next = S_SCAN;
            end
            S_SCAN: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (xfer && x_last && y_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        pix_valid = (state == S_SCAN);
        busy      = (state == S_SCAN);
        done      = (state == S_DONE);
        // Gated with pix_valid so IDLE/DONE present all-zero pixel fields.
        pix_data  = pix_valid && snap[y_cnt][x_cnt];
        pix_eol   = pix_valid && x_last;
        pix_eof   = pix_valid && x_last && y_last;
        // Counters are zero outside a frame, so no gating is needed here.
        pix_x     = COORD_BITS'(x_cnt);
        pix_y     = COORD_BITS'(y_cnt);
    end

    // ---------------- snapshot and counters ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            snap  <= '0;
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (frame_start) begin
            snap  <= picture;
            x_cnt <= '0;
            y_cnt <= '0;
        end else if ((state == S_SCAN) && abort) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (xfer) begin
            // The final transfer wraps both counters back to (0,0).
            if (x_last) begin
                x_cnt <= '0;
                y_cnt <= y_last ? '0 : y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

`ifdef SCANOUT_PIXCNT_EN
    // Holds its final value through DONE and IDLE until the next start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            set_count <= '0;
        end else if (frame_start) begin
            set_count <= '0;
        end else if (xfer && pix_data) begin
            set_count <= set_count + 1'b1;
        end
    end
`endif

endmodule

// File: doc/raster_scanout.md
Name: raster_scanout

Overview:
- Reader side of the line-drawing pixel buffer: on start, snapshots the 64x64 1-bit picture written by the line rasteriser.
- Streams the snapshot out one pixel per handshake in raster order (y outer, x inner) with coordinates and line/frame markers.
- Sits between the rasteriser's picture output and the downstream display/compare logic.

Parameters:
- WIDTH, 64, pixels per row.
- HEIGHT, 64, rows per frame.
- COORD_BITS, 8, width of pix_x/pix_y; values zero-extended from the internal counters.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  begin a frame; sampled only in IDLE.
- abort  in  1  synchronous cancel of the frame in progress.
- picture  in  [HEIGHT-1:0][WIDTH-1:0]  source bitmap, pixel (x,y) = picture[y][x].
- pix_ready  in  1  downstream accepts current pixel.
- pix_valid  out  1  pix_* outputs hold a pixel.
- pix_data  out  1  pixel value.
- pix_x  out  COORD_BITS  column of current pixel.
- pix_y  out  COORD_BITS  row of current pixel.
- pix_eol  out  1  current pixel is x = WIDTH-1.
- pix_eof  out  1  current pixel is (WIDTH-1, HEIGHT-1).
- busy  out  1  high in SCAN.
- done  out  1  one-cycle pulse after the last pixel transfers.

Behaviour:
- Reset (async, n_rst low): state IDLE; snapshot cleared; x/y counters 0; pix_valid, pix_data, pix_eol, pix_eof, busy and done all 0; pix_x and pix_y 0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 at an edge: picture is copied into the internal snapshot register, counters are set to (0,0), and the state moves to SCAN.
  - pix_valid goes high in the next cycle with pixel (0,0). Latency is 1 cycle from start to first valid.
- SCAN:
  - pix_valid=1, busy=1.
  - Outputs are combinational from the counters and the snapshot: pix_data = snap[y][x].
  - pix_eol and pix_eof decode from the counters.
- Transfer occurs on a cycle with pix_valid && pix_ready. On transfer:
  - x increments.
  - At x = WIDTH-1, x wraps to 0 and y increments.
  - At (WIDTH-1, HEIGHT-1), the state moves to DONE.
- No transfer (pix_ready=0): every pix_* output holds stable. pix_valid never drops in SCAN without a transfer or an abort.
- Full rate: with pix_ready held high, one pixel per cycle, WIDTH*HEIGHT cycles per frame.
- DONE: done=1 for exactly one cycle, pix_valid=0, busy=0, then the state returns to IDLE.
- start outside IDLE is ignored. picture changes after the snapshot do not affect the frame.
- abort=1 in SCAN: the state returns to IDLE at the next edge, pix_valid drops, counters clear, and done is not pulsed. abort takes priority over a simultaneous transfer.
- abort in IDLE or DONE has no effect. In IDLE, abort and start together: abort wins and the frame does not start.
- start in the DONE cycle is ignored; start must be reasserted in IDLE.
- Reset mid-frame: immediate return to the reset values above; no done pulse.

Optional Feature:
- Macro SCANOUT_PIXCNT_EN.
- Defined: adds output set_count [12:0] (width $clog2(WIDTH*HEIGHT+1)).
  - Cleared to 0 on reset and when a frame starts.
  - Increments on each transfer with pix_data=1.
  - Holds its final value through DONE and IDLE until the next start.
- Undefined: no port and no counter logic.

Test Plan:
- Reset then idle: n_rst=0 for 3 cycles, then 1 with start=0 -> pix_valid=0, busy=0, done=0 and pix_x=pix_y=0 throughout.
- Diagonal frame:
  - Stimulus: picture has only (0,0) to (9,8) set as the rasteriser draws it; start pulsed; pix_ready=1.
  - Response: 4096 consecutive transfers; pix_data=1 exactly at the line's pixels (e.g. (0,0), (9,8)); pix_eol on every x=63; pix_eof only at (63,63).
  - Response: done pulses once at cycle 4097 after start; with SCANOUT_PIXCNT_EN, set_count=10.
- Backpressure: pix_ready toggled 0/1 every cycle at (5,0) -> pix_x/pix_y/pix_data stable while ready=0; no pixel skipped or duplicated; the frame takes 8192 cycles.
- Snapshot isolation: picture all-ones at start, then changed to all-zeros one cycle later -> all 4096 pixels read 1.
- Abort: abort asserted after 100 transfers with pix_ready=1 -> pix_valid=0 next cycle and no done pulse; a new start then restarts at (0,0).
- Ignored start and mid-frame reset:
  - start held high through SCAN -> exactly one frame, then a new frame only after the IDLE sample.
  - n_rst low at (20,3) -> all outputs 0 immediately.
